// File: rtl/dct2d.sv
// 8x8 orthonormal 2-D DCT-II: a registered row pass, then a registered column pass with saturation.
module dct2d #(
  parameter int unsigned N  = 16,
  parameter int unsigned CF = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N*64-1:0] data_in,
  output logic            out_valid,
  output logic [N*64-1:0] data_out
);

  localparam int unsigned NE  = 8;
  localparam int unsigned BW  = N * NE * NE;
  localparam int unsigned CW  = CF + 2;
  localparam int unsigned RW  = N + 4;
  localparam int unsigned AW1 = N + CF + 6;
  localparam int unsigned AW2 = RW + CF + 6;

  localparam logic signed [AW1-1:0] HALF1  = AW1'(2 ** (CF - 1));
  localparam logic signed [AW2-1:0] HALF2  = AW2'(2 ** (CF - 1));
  localparam logic signed [AW2-1:0] SAT_HI = AW2'(2 ** (N - 1) - 1);
  localparam logic signed [AW2-1:0] SAT_LO = ~SAT_HI;

  // Cosine basis K[u][x] = round(2^CF * 0.5 * c(u) * cos((2x+1)u*pi/16)), CF = 12.
  localparam int KT [8][8] = '{
    '{1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
    '{2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
    '{1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
    '{1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
    '{1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
    '{1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
    '{ 784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
    '{ 400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
  };

  function automatic logic signed [CW-1:0] kc(input int u, input int x);
    return CW'(KT[u][x]);
  endfunction

  logic signed [N-1:0]   samp  [NE][NE];
  logic signed [RW-1:0]  row_d [NE][NE];
  logic signed [RW-1:0]  row_q [NE][NE];
  logic signed [AW1-1:0] acc1;
  logic signed [AW2-1:0] acc2;
  logic [BW-1:0]         dout_d;
  logic [BW-1:0]         dout_q;
  logic                  v1_q;
  logic                  ov_q;

  // Unpack the flat input bus; element (r,c) sits at field 63-(8r+c), so (0,0) is the MSB field.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        samp[r][c] = data_in[(63 - (8 * r + c)) * N +: N];
      end
    end
  end

  // Row pass: 1-D DCT along each row, round half-up via add-then-arithmetic-shift.
  always_comb begin
    row_d = '{default: '0};
    acc1  = '0;
    for (int r = 0; r < 8; r++) begin
      for (int u = 0; u < 8; u++) begin
        acc1 = '0;
        for (int c = 0; c < 8; c++) begin
          acc1 = acc1 + AW1'(samp[r][c]) * AW1'(kc(u, c));
        end
        row_d[r][u] = RW'((acc1 + HALF1) >>> CF);
      end
    end
  end

  // Stage-1 register: captures row-pass results only when a block is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      for (int r = 0; r < 8; r++) begin
        for (int u = 0; u < 8; u++) begin
          row_q[r][u] <= '0;
        end
      end
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        for (int r = 0; r < 8; r++) begin
          for (int u = 0; u < 8; u++) begin
            row_q[r][u] <= row_d[r][u];
          end
        end
      end
    end
  end

  // Column pass: 1-D DCT down each column of R, then saturate to N bits and pack as (v',u).
  always_comb begin
    dout_d = '0;
    acc2   = '0;
    for (int v = 0; v < 8; v++) begin
      for (int u = 0; u < 8; u++) begin
        acc2 = '0;
        for (int r = 0; r < 8; r++) begin
          acc2 = acc2 + AW2'(row_q[r][u]) * AW2'(kc(v, r));
        end
        acc2 = (acc2 + HALF2) >>> CF;
        if (acc2 > SAT_HI) begin
          dout_d[(63 - (8 * v + u)) * N +: N] = N'(SAT_HI);
        end else if (acc2 < SAT_LO) begin
          dout_d[(63 - (8 * v + u)) * N +: N] = N'(SAT_LO);
        end else begin
          dout_d[(63 - (8 * v + u)) * N +: N] = N'(acc2);
        end
      end
    end
  end

  // Stage-2 register: output bus updates only for a valid block and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      ov_q <= v1_q;
      if (v1_q) begin
        dout_q <= dout_d;
      end
    end
  end

  assign out_valid = ov_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_dct2d.sv
// Scoreboard bench for dct2d: expected blocks are queued at drive time and compared as outputs emerge.
module tb_dct2d;

  localparam int N  = 16;
  localparam int CF = 12;
  localparam int W  = N * 64;
  localparam real PI = 3.14159265358979323846;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         out_valid;
  logic [W-1:0] data_out;

  int           kt [8][8];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  int           run = 0;
  int           max_run = 0;
  logic [W-1:0] exp_q [$];
  string        tag_q [$];

  dct2d #(.N(N), .CF(CF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .data_in  (data_in),
    .out_valid(out_valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Compare one observation; on mismatch report the first differing field.
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    int idx;
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      idx = 0;
      for (int i = 63; i >= 0; i--) begin
        if (obs[(63 - i) * N +: N] !== expv[(63 - i) * N +: N]) idx = i;
      end
      $display("FAIL %s: elem %0d got %0d exp %0d", tag, idx,
               $signed(obs[(63 - idx) * N +: N]), $signed(expv[(63 - idx) * N +: N]));
    end
  endtask

  function automatic logic [N-1:0] fld(input logic [W-1:0] v, input int idx);
    return v[(63 - idx) * N +: N];
  endfunction

  function automatic logic [W-1:0] fill(input logic [N-1:0] v);
    logic [W-1:0] o;
    for (int i = 0; i < 64; i++) o[i * N +: N] = v;
    return o;
  endfunction

  function automatic logic [W-1:0] one_at(input int idx, input logic [N-1:0] v);
    logic [W-1:0] o;
    o = '0;
    o[(63 - idx) * N +: N] = v;
    return o;
  endfunction

  function automatic int kref(input int u, input int x);
    real s, v;
    s = (u == 0) ? $sqrt(0.5) : 1.0;
    v = 4096.0 * 0.5 * s * $cos(real'((2 * x + 1) * u) * PI / 16.0);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    return -$rtoi($floor(-v + 0.5));
  endfunction

  // Bit-exact fixed-point reference: row pass, column pass, saturate.
  function automatic logic [W-1:0] ref_dct(input logic [W-1:0] blk);
    longint f [8][8];
    longint rr [8][8];
    longint acc;
    logic [W-1:0] o;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        f[r][c] = longint'($signed(blk[(63 - (8 * r + c)) * N +: N]));
    for (int r = 0; r < 8; r++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int c = 0; c < 8; c++) acc += f[r][c] * longint'(kt[u][c]);
        rr[r][u] = (acc + (longint'(1) <<< (CF - 1))) >>> CF;
      end
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int r = 0; r < 8; r++) acc += rr[r][u] * longint'(kt[v][r]);
        acc = (acc + (longint'(1) <<< (CF - 1))) >>> CF;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        o[(63 - (8 * v + u)) * N +: N] = acc[N-1:0];
      end
    return o;
  endfunction

  task automatic send(input logic [W-1:0] blk, input logic [W-1:0] expv, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = blk;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rand_blk();
    logic [W-1:0] o;
    for (int i = 0; i < 64; i++) o[i * N +: N] = N'($urandom);
    return o;
  endfunction

  // Output monitor: pop the scoreboard on every valid output, track consecutive valid runs.
  always @(negedge clk) begin
    string t;
    if (rst_n && out_valid) begin
      n_out++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", W'(1), W'(0));
      end else begin
        t = tag_q.pop_front();
        chk(t, data_out, exp_q.pop_front());
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got %0t exp below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] blk;
    int  base;
    int  ok;
    real cu, cv, fl, d;

    rst_n = 1'b0;
    for (int u = 0; u < 8; u++)
      for (int x = 0; x < 8; x++)
        kt[u][x] = kref(u, x);

    #1;
    chk("rst_data", data_out, '0);
    chk("rst_valid", W'(out_valid), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Constant block, with latency and hold checks
    send(fill(16'd100), one_at(0, 16'd800), "const100");
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_early", W'(out_valid), W'(0));
    @(negedge clk);
    chk("lat_due", W'(out_valid), W'(1));
    idle(3);
    chk("hold_data", data_out, one_at(0, 16'd800));
    chk("hold_valid", W'(out_valid), W'(0));

    // Impulse at (0,0)
    blk = one_at(0, 16'd256);
    send(blk, ref_dct(blk), "impulse");
    idle(4);
    chk("impulse_dc", W'(fld(data_out, 0)), W'(16'd32));
    ok = 0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        cu = (u == 0) ? $sqrt(0.5) : 1.0;
        cv = (v == 0) ? $sqrt(0.5) : 1.0;
        fl = 256.0 * 0.25 * cu * cv * $cos(real'(u) * PI / 16.0) * $cos(real'(v) * PI / 16.0);
        d  = $itor($signed(fld(data_out, 8 * u + v)));
        if ((d - fl) <= 1.0 && (fl - d) <= 1.0) ok++;
      end
    chk("impulse_tol", W'(ok), W'(64));

    // Saturation, back to back
    send(fill(16'h7fff), one_at(0, 16'h7fff), "sat_pos");
    send(fill(16'h8000), one_at(0, 16'h8000), "sat_neg");
    idle(4);

    // Throughput: 16 random blocks on consecutive cycles
    base    = n_out;
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      blk = rand_blk();
      send(blk, ref_dct(blk), $sformatf("rand%0d", i));
    end
    idle(4);
    chk("tput_count", W'(n_out - base), W'(16));
    chk("tput_run", W'(max_run), W'(16));

    // Packing: single sample in the LSB field (7,7)
    blk = one_at(63, 16'd1000);
    send(blk, ref_dct(blk), "pack77");
    idle(4);
    chk("pack_dc", W'(fld(data_out, 0)), W'(16'd125));
    chk("pack_lsb", W'(fld(data_out, 63)), W'(16'd10));

    // Asynchronous reset with blocks in flight
    send(rand_blk(), '0, "inflight_a");
    send(rand_blk(), '0, "inflight_b");
    @(posedge clk);
    #1;
    chk("pre_rst_valid", W'(out_valid), W'(1));
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    tag_q.delete();
    #1;
    chk("rst_mid_data", data_out, '0);
    chk("rst_mid_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    base  = n_out;
    idle(5);
    chk("no_stale_valid", W'(n_out - base), W'(0));

    // First block after release
    send(fill(16'd100), one_at(0, 16'd800), "post_rst_const");
    idle(4);
    chk("sb_empty", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct2d.md
Name: dct2d

Overview:
- Computes the 8x8 two-dimensional DCT-II (orthonormal scaling) of one block of 64 signed N-bit samples, packed into a single flat bus.
- Used by the image-compression path: a 128x128 image is tiled into 8x8 windows, and each window is fed through this block.
- Fully pipelined fixed-point datapath: a row pass, then a column pass.
- Accepts one block per clock; fixed latency of 2 cycles.

Parameters:
- N, 16, signed sample/coefficient width in bits (input and output).
- CF, 12, fractional bits of the cosine constants.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in holds a block to process this cycle.
- data_in  input  N*64  input block, signed samples.
- out_valid  output  1  data_out holds a finished coefficient block.
- data_out  output  N*64  output block, signed DCT coefficients.

Behaviour:
- Packing (both buses): element (r,c), r = row, c = column, 0..7, occupies bits [(63-(8r+c))*N +: N].
  - (0,0) is therefore the most significant N bits; (7,7) is the least significant.
  - For data_out, (u,v) = (vertical frequency, horizontal frequency); (0,0) is DC.
- Constants: K[u][x] = round(2^CF * 0.5 * c(u) * cos((2x+1)*u*pi/16)).
  - c(0) = 1/sqrt(2); c(u>0) = 1.
  - Rounding is to nearest, half away from zero. Example: K[0][x] = 1448.
  - Constants are hard-coded as signed (CF+2)-bit values.
- Stage 1 (row pass), registered on the clk edge where in_valid=1:
  - R[r][u] = (sum over c of f(r,c)*K[u][c] + 2^(CF-1)) >>> CF.
  - >>> is an arithmetic right shift, i.e. floor after adding the half-LSB.
  - Keep R at N+4 bits signed; no saturation at this stage.
  - Accumulate at full precision (at least N+CF+6 bits) so no intermediate overflow occurs.
- Stage 2 (column pass), registered on the next edge:
  - F[v'][u] = (sum over r of R[r][u]*K[v'][r] + 2^(CF-1)) >>> CF.
  - Saturate the result to signed N-bit range [-2^(N-1), 2^(N-1)-1].
  - Output mapping: data_out element (u,v) = F[u][v], where the first index is the column-pass (vertical) frequency and the second is the row-pass (horizontal) frequency.
- Valid pipeline: in_valid is delayed 2 cycles to produce out_valid.
  - A block presented at edge k appears on data_out with out_valid=1 after edge k+2.
  - Back-to-back blocks are accepted every cycle; there is no backpressure.
- When in_valid=0, the stage registers hold their previous contents.
  - data_out keeps its last value while out_valid=0.
  - Consumers must qualify data_out with out_valid.
- Reset (asynchronous, active-low):
  - All pipeline registers, data_out and out_valid clear to 0 immediately.
  - Blocks in flight are discarded.
  - The first valid output after reset release is the block presented on or after the first post-release edge.
- Determinism: identical input always gives identical output; the result is independent of the previous block.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with blocks in flight -> data_out=0 and out_valid=0 immediately. After release, no stale out_valid pulse appears.
- Constant block: all 64 samples = 100, in_valid one cycle -> two cycles later out_valid=1, DC (MSB field) = 800, the other 63 coefficients = 0.
- Impulse: sample (0,0) = 256, others 0 -> DC = 32. Every output coefficient is within ±1 of the floating-point orthonormal DCT result (256/8 * basis product).
- Saturation: all samples = 32767 -> DC = 32767 (saturated), AC = 0. All samples = -32768 -> DC = -32768, AC = 0.
- Throughput: 16 distinct random blocks on consecutive cycles -> 16 consecutive out_valid cycles, in order. Each block matches a bit-exact reference model of the same fixed-point algorithm.
- Packing check: single sample (7,7) = 1000 placed in the LSB field -> the output is a nonzero, symmetric-magnitude pattern that matches the reference model. This confirms (7,7) maps to the LSB field on both buses.
